alarm_sound_ctrl: RTL

ALARM_SOUND_CTRL -- requirements
Module: alarm_sound_ctrl

---
 rtl/alarm_clock_pkg.sv | 16 +
 rtl/alarm_time_cmp.sv | 20 ++
 rtl/alarm_sound_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared alarm clock definitions: alarm FSM state encoding and default timing constants.
package alarm_clock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_DONE    = 3'd4
  } alarm_state_t;

  localparam int SNOOZE_MIN_DEF   = 5;
  localparam int RING_MAX_MIN_DEF = 10;
  localparam int MAX_SNOOZE_DEF   = 3;

endpackage

// File: rtl/alarm_time_cmp.sv
// Combinational compare of the BCD current time against the BCD alarm time.
module alarm_time_cmp (
  input  logic [3:0] cur_ms_hr,
  input  logic [3:0] cur_ls_hr,
  input  logic [3:0] cur_ms_min,
  input  logic [3:0] cur_ls_min,
  input  logic [3:0] alm_ms_hr,
  input  logic [3:0] alm_ls_hr,
  input  logic [3:0] alm_ms_min,
  input  logic [3:0] alm_ls_min,
  output logic       match
);

  // All four digits must agree; no BCD validity checking is done here.
  assign match = (cur_ms_hr  == alm_ms_hr)  &&
                 (cur_ls_hr  == alm_ls_hr)  &&
                 (cur_ms_min == alm_ms_min) &&
                 (cur_ls_min == alm_ls_min);

endmodule

// File: rtl/alarm_sound_ctrl.sv
// Alarm sound controller: arms on enable, rings on time match, handles snooze,
// stop and auto-silence, and waits for the matching minute to pass before re-arming.
module alarm_sound_ctrl
  import alarm_clock_pkg::*;
#(
  parameter int SNOOZE_MIN   = SNOOZE_MIN_DEF,
  parameter int RING_MAX_MIN = RING_MAX_MIN_DEF,
  parameter int MAX_SNOOZE   = MAX_SNOOZE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_minute,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic       sound_alarm,
  output logic       snoozing
);

  // Ring counter value on which the next minute pulse ends ringing.
  localparam logic [3:0] RING_LAST = 4'(RING_MAX_MIN - 1);
  localparam logic [3:0] SNZ_LOAD  = 4'(SNOOZE_MIN);
  localparam logic [1:0] SNZ_LIMIT = 2'(MAX_SNOOZE);

  alarm_state_t r_state;
  logic [3:0]   r_ring_cnt;
  logic [3:0]   r_snz_tmr;
  logic [1:0]   r_snz_cnt;
  logic         w_match;
  logic         w_snz_ok;

  alarm_time_cmp u_cmp (
    .cur_ms_hr  (current_time_ms_hr),
    .cur_ls_hr  (current_time_ls_hr),
    .cur_ms_min (current_time_ms_min),
    .cur_ls_min (current_time_ls_min),
    .alm_ms_hr  (alarm_time_ms_hr),
    .alm_ls_hr  (alarm_time_ls_hr),
    .alm_ms_min (alarm_time_ms_min),
    .alm_ls_min (alarm_time_ls_min),
    .match      (w_match)
  );

  // A snooze press only counts while snoozes remain; otherwise it is as if absent.
  assign w_snz_ok = snooze && (r_snz_cnt < SNZ_LIMIT);

  // Alarm FSM with its ring, snooze-timer and snooze-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
    end else if (!alarm_en) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_ARMED;
        ST_ARMED: begin
          if (w_match) begin
            r_state    <= ST_RINGING;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
          end
        end
        ST_RINGING: begin
          // stop beats snooze, and an accepted snooze swallows the minute pulse
          if (stop) begin
            r_state <= ST_DONE;
          end else if (w_snz_ok) begin
            r_state   <= ST_SNOOZE;
            r_snz_tmr <= SNZ_LOAD;
            r_snz_cnt <= r_snz_cnt + 2'd1;
          end else if (one_minute) begin
            if (r_ring_cnt == RING_LAST) r_state <= ST_DONE;
            else                         r_ring_cnt <= r_ring_cnt + 4'd1;
          end
        end
        ST_SNOOZE: begin
          if (stop) begin
            r_state <= ST_DONE;
          end else if (one_minute) begin
            r_snz_tmr <= r_snz_tmr - 4'd1;
            if (r_snz_tmr == 4'd1) begin
              r_state    <= ST_RINGING;
              r_ring_cnt <= '0;
            end
          end
        end
        ST_DONE: begin
          // hold until the alarm minute has passed so ringing cannot retrigger
          if (!w_match) r_state <= ST_ARMED;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sound_alarm = (r_state == ST_RINGING);
  assign snoozing    = (r_state == ST_SNOOZE);

endmodule
